// File: rtl/mdu_ctrl.sv
// RV32M multiply/divide sequencer: operand sign stripping, unit launch,
// sign correction and divide special cases with a registered result.
module mdu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic [2:0]        funct3_in,
  input  logic [XLEN-1:0]   op1_in,
  input  logic [XLEN-1:0]   op2_in,
  input  logic              flush_in,
  output logic              stall_out,
  output logic              done_out,
  output logic [XLEN-1:0]   result_out,
  output logic              reg_we_out,
  output logic              mul_req_out,
  output logic [XLEN-1:0]   mul_a_out,
  output logic [XLEN-1:0]   mul_b_out,
  input  logic              mul_ready_in,
  input  logic [2*XLEN-1:0] mul_result_in,
  output logic              div_req_out,
  output logic [XLEN-1:0]   div_dividend_out,
  output logic [XLEN-1:0]   div_divisor_out,
  output logic              div_is_rem_out,
  input  logic              div_ready_in,
  input  logic [XLEN-1:0]   div_result_in
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              s1, s2;
  logic              mag1, mag2;
  logic              sgn_ovf;
  logic [2*XLEN-1:0] prod_sel;
  logic [XLEN-1:0]   mul_fix;
  logic [XLEN-1:0]   div_fix;

  assign s1 = op1_in[XLEN-1];
  assign s2 = op2_in[XLEN-1];

  assign mag1 = (funct3_in == 3'd1) || (funct3_in == 3'd2) ||
                (funct3_in == 3'd4) || (funct3_in == 3'd6);
  assign mag2 = (funct3_in == 3'd1) || (funct3_in == 3'd4) ||
                (funct3_in == 3'd6);

  assign sgn_ovf = !funct3_in[0] && (op1_in == MIN_NEG) &&
                   (op2_in == {XLEN{1'b1}});

  // neg_q is only ever set for signed ops, so MUL/MULHU pass through.
  assign prod_sel = neg_q ? -mul_result_in : mul_result_in;
  assign mul_fix  = (f3_q[1:0] == 2'd0) ? prod_sel[XLEN-1:0]
                                        : prod_sel[2*XLEN-1:XLEN];
  assign div_fix  = neg_q ? -div_result_in : div_result_in;

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    if (flush_in) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_in) begin
            f3_d = funct3_in;
            a_d  = (mag1 && s1) ? -op1_in : op1_in;
            b_d  = (mag2 && s2) ? -op2_in : op2_in;
            unique case (funct3_in)
              3'd1, 3'd4: neg_d = s1 ^ s2;
              3'd2, 3'd6: neg_d = s1;
              default:    neg_d = 1'b0;
            endcase
            if (!funct3_in[2]) begin
              state_d = S_MUL;
            end else if (op2_in == '0) begin
              res_d   = funct3_in[1] ? op1_in : {XLEN{1'b1}};
              state_d = S_DONE;
            end else if (sgn_ovf) begin
              res_d   = funct3_in[1] ? '0 : op1_in;
              state_d = S_DONE;
            end else begin
              state_d = S_DIV;
            end
          end
        end
        S_MUL: begin
          if (mul_ready_in) begin
            res_d   = mul_fix;
            state_d = S_DONE;
          end
        end
        S_DIV: begin
          if (div_ready_in) begin
            res_d   = div_fix;
            state_d = S_DONE;
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign stall_out = ((state_q == S_IDLE) && start_in) ||
                     (state_q == S_MUL) || (state_q == S_DIV);
  assign done_out   = (state_q == S_DONE);
  assign reg_we_out = done_out;
  assign result_out = res_q;

  assign mul_req_out      = (state_q == S_MUL);
  assign mul_a_out        = a_q;
  assign mul_b_out        = b_q;
  assign div_req_out      = (state_q == S_DIV);
  assign div_dividend_out = a_q;
  assign div_divisor_out  = b_q;
  assign div_is_rem_out   = f3_q[1];

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: a latency-programmable unit stand-in
// returns hand-computed raw unit results; expected values are constants.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        start_in;
  logic [2:0]  funct3_in;
  logic [31:0] op1_in, op2_in;
  logic        flush_in;
  logic        stall_out, done_out, reg_we_out;
  logic [31:0] result_out;
  logic        mul_req_out, mul_ready_in;
  logic [31:0] mul_a_out, mul_b_out;
  logic [63:0] mul_result_in;
  logic        div_req_out, div_is_rem_out, div_ready_in;
  logic [31:0] div_dividend_out, div_divisor_out, div_result_in;

  int pass_cnt = 0;
  int total_cnt = 0;

  mdu_ctrl #(.XLEN(32)) dut (
    .clk_in           (clk),
    .reset_in         (reset_in),
    .start_in         (start_in),
    .funct3_in        (funct3_in),
    .op1_in           (op1_in),
    .op2_in           (op2_in),
    .flush_in         (flush_in),
    .stall_out        (stall_out),
    .done_out         (done_out),
    .result_out       (result_out),
    .reg_we_out       (reg_we_out),
    .mul_req_out      (mul_req_out),
    .mul_a_out        (mul_a_out),
    .mul_b_out        (mul_b_out),
    .mul_ready_in     (mul_ready_in),
    .mul_result_in    (mul_result_in),
    .div_req_out      (div_req_out),
    .div_dividend_out (div_dividend_out),
    .div_divisor_out  (div_divisor_out),
    .div_is_rem_out   (div_is_rem_out),
    .div_ready_in     (div_ready_in),
    .div_result_in    (div_result_in)
  );

  always #5 clk = ~clk;

  // Issues one op and plays the unit: ready goes high `lat` cycles after
  // the first req cycle. Collects observations over a bounded window.
  task automatic run_op(
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] prod,
    input  logic [31:0] dres,
    input  int          lat,
    output logic [31:0] res,
    output int          stall_n,
    output int          done_n,
    output int          done_c,
    output int          mreq_n,
    output int          dreq_n,
    output logic [31:0] oa,
    output logic [31:0] ob,
    output logic        isrem
  );
    int req_cnt;
    req_cnt = 0; stall_n = 0; done_n = 0; done_c = -1;
    mreq_n = 0; dreq_n = 0; res = 'x; oa = 'x; ob = 'x; isrem = 1'bx;
    @(negedge clk);
    funct3_in = f3; op1_in = a; op2_in = b;
    mul_result_in = prod; div_result_in = dres;
    start_in = 1'b1;
    #1;
    if (stall_out) stall_n++;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      start_in = 1'b0; mul_ready_in = 1'b0; div_ready_in = 1'b0;
      #1;
      if (stall_out) stall_n++;
      if (done_out) begin
        done_n++;
        if (done_c < 0) done_c = c;
        res = result_out;
      end
      if (mul_req_out) begin
        mreq_n++; oa = mul_a_out; ob = mul_b_out;
      end
      if (div_req_out) begin
        dreq_n++; oa = div_dividend_out; ob = div_divisor_out;
        isrem = div_is_rem_out;
      end
      if (mul_req_out || div_req_out) begin
        req_cnt++;
        if (req_cnt == lat + 1) begin
          mul_ready_in = mul_req_out;
          div_ready_in = div_req_out;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if ({stall_out, done_out, reg_we_out, mul_req_out, div_req_out}
        !== 5'b0) $display("FAIL reset_ctl got=%b want=00000",
        {stall_out, done_out, reg_we_out, mul_req_out, div_req_out});
    else pass_cnt++;
    total_cnt++;
    if (result_out !== 32'h0)
      $display("FAIL reset_result got=%h want=0", result_out);
    else pass_cnt++;
    total_cnt++;
    if ({mul_a_out, mul_b_out} !== 64'h0)
      $display("FAIL reset_operands got=%h want=0", {mul_a_out, mul_b_out});
    else pass_cnt++;
  endtask

  task automatic test_mulh();
    logic [31:0] r, oa, ob; logic ir;
    int sn, dn, dc, mn, xn;
    run_op(3'd1, 32'hFFFF_FFFE, 32'h3, 64'd6, 32'h0, 3,
           r, sn, dn, dc, mn, xn, oa, ob, ir);
    total_cnt++;
    if (oa !== 32'd2 || ob !== 32'd3)
      $display("FAIL mulh_operands got=%h/%h want=2/3", oa, ob);
    else pass_cnt++;
    total_cnt++;
    if (r !== 32'hFFFF_FFFF)
      $display("FAIL mulh_result got=%h want=ffffffff", r);
    else pass_cnt++;
    total_cnt++;
    if (dn !== 1 || dc !== 4)
      $display("FAIL mulh_done got=%0d@%0d want=1@4", dn, dc);
    else pass_cnt++;
    total_cnt++;
    if (sn !== 5) $display("FAIL mulh_stall got=%0d want=5", sn);
    else pass_cnt++;
    total_cnt++;
    if (mn !== 4 || xn !== 0)
      $display("FAIL mulh_req got=%0d/%0d want=4/0", mn, xn);
    else pass_cnt++;
  endtask

  task automatic test_div();
    logic [31:0] r, oa, ob; logic ir;
    int sn, dn, dc, mn, xn;
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 64'h0, 32'd3, 1,
           r, sn, dn, dc, mn, xn, oa, ob, ir);
    total_cnt++;
    if (oa !== 32'd7 || ob !== 32'd2 || ir !== 1'b0)
      $display("FAIL div_operands got=%h/%h/%b want=7/2/0", oa, ob, ir);
    else pass_cnt++;
    total_cnt++;
    if (r !== 32'hFFFF_FFFD || dn !== 1 || dc !== 2)
      $display("FAIL div_result got=%h n=%0d@%0d want=fffffffd n=1@2",
               r, dn, dc);
    else pass_cnt++;
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 64'h0, 32'd1, 0,
           r, sn, dn, dc, mn, xn, oa, ob, ir);
    total_cnt++;
    if (ir !== 1'b1 || oa !== 32'd7)
      $display("FAIL rem_operands got=%h/%b want=7/1", oa, ir);
    else pass_cnt++;
    total_cnt++;
    if (r !== 32'hFFFF_FFFF || dn !== 1 || sn !== 2)
      $display("FAIL rem_result got=%h n=%0d s=%0d want=ffffffff n=1 s=2",
               r, dn, sn);
    else pass_cnt++;
  endtask

  task automatic test_div_special();
    logic [2:0]  f3s [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] a1s [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] a2s [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] r, oa, ob; logic ir;
    int sn, dn, dc, mn, xn;
    for (int i = 0; i < 4; i++) begin
      run_op(f3s[i], a1s[i], a2s[i], 64'h0, 32'h1234_5678, 0,
             r, sn, dn, dc, mn, xn, oa, ob, ir);
      total_cnt++;
      if (r !== exp[i] || dn !== 1 || dc !== 0 || xn !== 0 || sn !== 1)
        $display("FAIL div_special%0d got=%h n=%0d@%0d req=%0d s=%0d want=%h n=1@0 req=0 s=1",
                 i, r, dn, dc, xn, sn, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mul_variants();
    logic [2:0]  f3s [3] = '{3'd2, 3'd3, 3'd0};
    logic [63:0] prd [3] = '{64'h0000_0000_FFFF_FFFF,
                             64'hFFFF_FFFE_0000_0001,
                             64'hFFFF_FFFE_0000_0001};
    logic [31:0] ea  [3] = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1};
    logic [31:0] r, oa, ob; logic ir;
    int sn, dn, dc, mn, xn;
    for (int i = 0; i < 3; i++) begin
      run_op(f3s[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, prd[i], 32'h0, 0,
             r, sn, dn, dc, mn, xn, oa, ob, ir);
      total_cnt++;
      if (oa !== ea[i] || ob !== 32'hFFFF_FFFF)
        $display("FAIL mulvar_ops%0d got=%h/%h want=%h/ffffffff",
                 i, oa, ob, ea[i]);
      else pass_cnt++;
      total_cnt++;
      if (r !== exp[i] || dn !== 1 || dc !== 1)
        $display("FAIL mulvar_res%0d got=%h n=%0d@%0d want=%h n=1@1",
                 i, r, dn, dc, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, r, oa, ob; logic ir;
    int sn, dn, dc, mn, xn, req_cnt, dseen, busy;
    prev = result_out;
    req_cnt = 0; dseen = 0; busy = 0;
    @(negedge clk);
    funct3_in = 3'd5; op1_in = 32'd100; op2_in = 32'd7;
    div_result_in = 32'd14; start_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start_in = 1'b0; div_ready_in = 1'b0; flush_in = 1'b0;
      #1;
      if (done_out || reg_we_out) dseen++;
      if (c > 2 && (stall_out || div_req_out)) busy++;
      if (div_req_out) begin
        req_cnt++;
        if (req_cnt == 2) begin
          div_ready_in = 1'b1; flush_in = 1'b1;
        end
      end
    end
    total_cnt++;
    if (dseen !== 0) $display("FAIL flush_done got=%0d want=0", dseen);
    else pass_cnt++;
    total_cnt++;
    if (result_out !== prev)
      $display("FAIL flush_result got=%h want=%h", result_out, prev);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 0 || req_cnt !== 2)
      $display("FAIL flush_idle busy=%0d req=%0d want=0/2", busy, req_cnt);
    else pass_cnt++;
    run_op(3'd5, 32'd100, 32'd7, 64'h0, 32'd14, 1,
           r, sn, dn, dc, mn, xn, oa, ob, ir);
    total_cnt++;
    if (r !== 32'd14 || dn !== 1 || dc !== 2)
      $display("FAIL flush_next got=%h n=%0d@%0d want=0000000e n=1@2",
               r, dn, dc);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [31:0] r, oa, ob; logic ir;
    int sn, dn, dc, mn, xn, busy;
    @(negedge clk);
    funct3_in = 3'd3; op1_in = 32'd9; op2_in = 32'd9;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    #1;
    total_cnt++;
    if (mul_req_out !== 1'b1 || result_out === 32'h0)
      $display("FAIL areset_pre req=%b res=%h want=1/nonzero",
               mul_req_out, result_out);
    else pass_cnt++;
    #1 reset_in = 1'b1;
    #1;
    total_cnt++;
    if (mul_req_out !== 1'b0 || stall_out !== 1'b0 ||
        result_out !== 32'h0 || done_out !== 1'b0)
      $display("FAIL areset_now req=%b stall=%b res=%h done=%b want=0/0/0/0",
               mul_req_out, stall_out, result_out, done_out);
    else pass_cnt++;
    #1 reset_in = 1'b0;
    busy = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (mul_req_out || div_req_out || stall_out || done_out) busy++;
    end
    total_cnt++;
    if (busy !== 0) $display("FAIL areset_idle got=%0d want=0", busy);
    else pass_cnt++;
    run_op(3'd0, 32'd6, 32'd7, 64'd42, 32'h0, 2,
           r, sn, dn, dc, mn, xn, oa, ob, ir);
    total_cnt++;
    if (r !== 32'd42 || dn !== 1 || dc !== 3)
      $display("FAIL areset_next got=%h n=%0d@%0d want=0000002a n=1@3",
               r, dn, dc);
    else pass_cnt++;
  endtask

  initial begin
    reset_in = 1'b1; start_in = 1'b0; funct3_in = '0;
    op1_in = '0; op2_in = '0; flush_in = 1'b0;
    mul_ready_in = 1'b0; mul_result_in = '0;
    div_ready_in = 1'b0; div_result_in = '0;
    test_reset();
    @(negedge clk);
    reset_in = 1'b0;
    test_mulh();
    test_div();
    test_div_special();
    test_mul_variants();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller for the RV32M multiply/divide datapath. It accepts one decoded M-type operation at a time from execute and latches its operands. It launches the shared `mul`/`div` units with sign-stripped magnitudes and holds the pipeline stall while a unit is busy. It then applies RISC-V sign correction and the divide special cases, and returns a registered result with a one-cycle `done_out` pulse.

## Interface
- `XLEN`, default 32: operand and result width.
- `clk_in` input 1: clock; all state updates on the rising edge.
- `reset_in` input 1: asynchronous, active-high reset.
- `start_in` input 1: an M-type operation is present on `funct3_in`/`op1_in`/`op2_in`; sampled only in IDLE.
- `funct3_in` input 3: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `op1_in`, `op2_in` input XLEN: rs1 and rs2 values.
- `flush_in` input 1: abort the operation in flight.
- `stall_out` output 1: hold the upstream pipeline.
- `done_out` output 1: one-cycle pulse; `result_out` is valid.
- `result_out` output XLEN: registered result, held until the next accepted start.
- `reg_we_out` output 1: equals `done_out`.
- `mul_req_out` output 1, `mul_a_out` output XLEN, `mul_b_out` output XLEN: multiplier request and operands.
- `mul_ready_in` input 1, `mul_result_in` input 2·XLEN: multiplier done pulse and product.
- `div_req_out` output 1, `div_dividend_out` output XLEN, `div_divisor_out` output XLEN: divider request and operands.
- `div_is_rem_out` output 1: select remainder instead of quotient.
- `div_ready_in` input 1, `div_result_in` input XLEN: divider done pulse and result.

## Operation
- States are IDLE, MUL, DIV and DONE. Reset sets state=IDLE. All outputs reset to 0 and the operand and result registers are cleared.
- **IDLE with `start_in`=1.** Latch funct3, the sign bits s1=op1[XLEN-1] and s2=op2[XLEN-1], and the operands.
  - Signed ops (MULH, DIV, REM) latch magnitudes of both operands; magnitude = two's-complement negate when the sign bit is 1. MULHSU negates only op1. MUL, MULHU, DIVU and REMU latch raw values.
  - Divide by zero (op2=0): go straight to DONE without launching the divider. Result is all-ones for DIV/DIVU and op1 for REM/REMU.
  - Signed overflow (DIV/REM with op1=0x80000000, op2=0xFFFFFFFF): go straight to DONE. Result is op1 for DIV and 0 for REM.
  - Otherwise go to MUL for funct3[2]=0 and to DIV for funct3[2]=1.
- **MUL / DIV.** `*_req_out`=1 and the operand outputs are driven from the latched registers, held stable while req is high. `div_is_rem_out`=funct3[1].
  - On the cycle `*_ready_in`=1, capture the corrected result into `result_out` and go to DONE.
- **Result correction.**
  - MUL: product[XLEN-1:0].
  - MULHU: product[2XLEN-1:XLEN].
  - MULH: high half of the 2·XLEN negated product when s1^s2, else high half of the product.
  - MULHSU: same rule as MULH using s1 only.
  - DIV: negate the quotient when s1^s2.
  - REM: negate the remainder when s1.
  - Unsigned divides: pass through.
- **DONE.** `done_out`=`reg_we_out`=1 for exactly one cycle, then IDLE. `start_in` is ignored in DONE.
- **`stall_out`** = (IDLE & `start_in`) | MUL | DIV. It is 0 in DONE so the pipeline advances on the `done_out` cycle.
- **`flush_in`** overrides all states: the next state is IDLE, req drops, no `done_out`, and `result_out` is unchanged. A `*_ready_in` arriving in the same cycle as the flush is discarded. The units restart cleanly on req deassertion.
- **Unexpected `*_ready_in`** outside MUL/DIV is ignored.

## Timing
- Start accepted at edge T. Req is high from cycle T+1. If the unit asserts ready in cycle T+1+L, DONE is cycle T+2+L. Stall is high from T through T+1+L.
- Special-case divides: DONE is cycle T+1, and no req is issued.
- Minimum spacing between accepted starts is 1 cycle after DONE, because IDLE is required.
- Reset asserted mid-operation: outputs and state clear immediately (asynchronous); req drops without waiting for a clock.

## Test plan
- **MULH:** op1=0xFFFFFFFE (-2), op2=0x00000003; unit model returns ready 3 cycles after req. Required: `mul_a_out`=2, `mul_b_out`=3, `result_out`=0xFFFFFFFF, `done_out` one pulse, stall high for 5 cycles.
- **DIV:** op1=0xFFFFFFF9 (-7), op2=2. Required: dividend 7, divisor 2, quotient 0xFFFFFFFD. REM with the same operands gives 0xFFFFFFFF.
- **Divide specials:**
  - DIVU 5/0 → 0xFFFFFFFF in cycle T+1 with `div_req_out` never asserted.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM with those overflow operands → 0.
- **MULHSU:** op1=0xFFFFFFFF, op2=0xFFFFFFFF → 0xFFFFFFFF. **MULHU** with the same operands → 0xFFFFFFFE. **MUL** with the same operands → 0x00000001.
- **Flush:** assert `flush_in` in the cycle `div_ready_in` pulses. Required: no `done_out`, `result_out` unchanged, state IDLE. The next start proceeds normally.
- **Async reset:** pulse `reset_in` between clock edges while in MUL. Required: `mul_req_out`, `stall_out` and `result_out` are 0 immediately, and state is IDLE.
